// File: rtl/mos6502s_dma_copy_if.sv
// mos6502s_dma_copy_if: memory bus between the copy engine (master) and the memory (slave)
interface mos6502s_dma_copy_if;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic        rw;
    logic        cs;
    logic [7:0]  rdata;

    modport master (output addr, wdata, rw, cs, input rdata);
    modport slave  (input addr, wdata, rw, cs, output rdata);
endinterface

// File: rtl/mos6502s_dma_copy.sv
// mos6502s_dma_copy: byte-serial forward block copy engine acting as a second bus master
module mos6502s_dma_copy #(
    parameter int LEN_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic                  abort_i,
    input  logic [15:0]           src_addr_i,
    input  logic [15:0]           dst_addr_i,
    input  logic [LEN_W-1:0]      len_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o,
    output logic [LEN_W-1:0]      count_o,
    mos6502s_dma_copy_if.master   mem
);
    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_e;

    localparam logic [LEN_W-1:0] ONE = LEN_W'(1);

    state_e            state_q, state_d;
    logic [15:0]       sp_q, sp_d, dp_q, dp_d;
    logic [LEN_W-1:0]  remain_q, remain_d, count_q, count_d;
    logic              err_q, err_d;
    logic [7:0]        byte_q, byte_d;

    // state and datapath registers; reset forces the bus idle immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            sp_q     <= '0;
            dp_q     <= '0;
            remain_q <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
            byte_q   <= '0;
        end else begin
            state_q  <= state_d;
            sp_q     <= sp_d;
            dp_q     <= dp_d;
            remain_q <= remain_d;
            count_q  <= count_d;
            err_q    <= err_d;
            byte_q   <= byte_d;
        end
    end

    // next state: one read then one write per byte; a write into ROM space is never issued
    always_comb begin
        state_d  = state_q;
        sp_d     = sp_q;
        dp_d     = dp_q;
        remain_d = remain_q;
        count_d  = count_q;
        err_d    = err_q;
        byte_d   = byte_q;
        case (state_q)
            IDLE: if (start_i) begin
                sp_d     = src_addr_i;
                dp_d     = dst_addr_i;
                remain_d = len_i;
                count_d  = '0;
                err_d    = (len_i != '0) && dst_addr_i[15];
                state_d  = (len_i == '0 || dst_addr_i[15]) ? DONE : READ;
            end
            READ: begin
                byte_d  = abort_i ? byte_q : mem.rdata;
                sp_d    = abort_i ? sp_q : sp_q + 16'd1;
                state_d = abort_i ? DONE : WRITE;
            end
            WRITE: begin
                dp_d     = dp_q + 16'd1;
                count_d  = count_q + ONE;
                remain_d = remain_q - ONE;
                err_d    = err_q | ((remain_d != '0) && dp_d[15]);
                state_d  = (remain_d == '0 || abort_i || dp_d[15]) ? DONE : READ;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign busy_o    = (state_q == READ) || (state_q == WRITE);
    assign done_o    = state_q == DONE;
    assign err_o     = err_q;
    assign count_o   = count_q;
    assign mem.cs    = busy_o;
    assign mem.rw    = state_q != WRITE;
    assign mem.addr  = (state_q == READ) ? sp_q : (state_q == WRITE) ? dp_q : 16'h0000;
    assign mem.wdata = (state_q == WRITE) ? byte_q : 8'h00;
endmodule

// File: tb/tb_mos6502s_dma_copy.sv
// tb_mos6502s_dma_copy: directed checks of the copy engine against a behavioural memory
module tb_mos6502s_dma_copy;
    logic        clk, rst, start, abort, busy, done, err;
    logic [15:0] src, dst, len, count;
    logic [7:0]  mem [0:65535];
    logic        rom_wr;
    int          errors = 0;
    int          checks = 0;

    mos6502s_dma_copy_if dif ();

    mos6502s_dma_copy #(.LEN_W(16)) dut (
        .clk(clk), .rst(rst), .start_i(start), .abort_i(abort),
        .src_addr_i(src), .dst_addr_i(dst), .len_i(len),
        .busy_o(busy), .done_o(done), .err_o(err), .count_o(count),
        .mem(dif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign dif.rdata = mem[dif.addr];

    always @(posedge clk) begin
        if (dif.cs && !dif.rw) begin
            if (dif.addr[15]) rom_wr = 1'b1;
            else mem[dif.addr] = dif.wdata;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic run_xfer(input logic [15:0] s, input logic [15:0] d, input logic [15:0] l,
                            output int dcyc, output logic cs_seen, output logic busy_seen);
        @(negedge clk);
        src = s; dst = d; len = l; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        dcyc = -1; cs_seen = 1'b0; busy_seen = 1'b0;
        for (int c = 1; c <= 200 && dcyc < 0; c++) begin
            if (dif.cs) cs_seen = 1'b1;
            if (busy) busy_seen = 1'b1;
            if (done) dcyc = c;
            else @(negedge clk);
        end
    endtask

    int   dc;
    logic cs_s, busy_s;

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; src = '0; dst = '0; len = '0; rom_wr = 1'b0;
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        mem[16'h8000] = 8'h11; mem[16'h8001] = 8'h22; mem[16'h8002] = 8'h33; mem[16'h8003] = 8'h44;
        for (int i = 0; i < 5; i++) mem[16'h0300 + i] = 8'(i + 1);
        repeat (2) @(negedge clk);
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset err", err, 0);
        chk("reset count", count, 0);
        chk("reset bus", {dif.cs, dif.rw, dif.addr, dif.wdata}, {1'b0, 1'b1, 16'h0000, 8'h00});
        rst = 1'b0;

        run_xfer(16'h8000, 16'h0200, 16'd4, dc, cs_s, busy_s);
        chk("copy done cycle", dc, 9);
        chk("copy count", count, 4);
        chk("copy err", err, 0);
        chk("copy ram0", mem[16'h0200], 8'h11);
        chk("copy ram1", mem[16'h0201], 8'h22);
        chk("copy ram2", mem[16'h0202], 8'h33);
        chk("copy ram3", mem[16'h0203], 8'h44);

        run_xfer(16'h8000, 16'h0200, 16'd0, dc, cs_s, busy_s);
        chk("zero done cycle", dc, 1);
        chk("zero cs", cs_s, 0);
        chk("zero busy", busy_s, 0);
        chk("zero count", count, 0);

        run_xfer(16'h8000, 16'h7FFE, 16'd4, dc, cs_s, busy_s);
        chk("rom done cycle", dc, 5);
        chk("rom err", err, 1);
        chk("rom count", count, 2);
        chk("rom ram 7ffe", mem[16'h7FFE], 8'h11);
        chk("rom ram 7fff", mem[16'h7FFF], 8'h22);

        run_xfer(16'h0200, 16'h8000, 16'd2, dc, cs_s, busy_s);
        chk("imm rom done cycle", dc, 1);
        chk("imm rom busy", busy_s, 0);
        chk("imm rom err", err, 1);

        mem[16'h0100] = 8'hAA;
        run_xfer(16'h0100, 16'h0101, 16'd3, dc, cs_s, busy_s);
        chk("fill done cycle", dc, 7);
        chk("fill err cleared", err, 0);
        chk("fill ram", {mem[16'h0101], mem[16'h0102], mem[16'h0103]}, 24'hAAAAAA);
        chk("fill stop", mem[16'h0104], 8'h00);

        @(negedge clk);
        src = 16'h0300; dst = 16'h0400; len = 16'd5; start = 1'b1;
        @(negedge clk);
        src = 16'h0000; dst = 16'h0500; len = 16'd1;
        chk("abort rd0 addr", dif.addr, 16'h0300);
        @(negedge clk);
        start = 1'b0;
        chk("abort wr0 bus", {dif.rw, dif.addr, dif.wdata}, {1'b0, 16'h0400, 8'h01});
        @(negedge clk);
        chk("abort rd1 addr", dif.addr, 16'h0301);
        @(negedge clk);
        @(negedge clk);
        chk("abort rd2 addr", dif.addr, 16'h0302);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort done", done, 1);
        chk("abort busy", busy, 0);
        chk("abort count", count, 2);
        chk("abort ram", {mem[16'h0400], mem[16'h0401], mem[16'h0402]}, 24'h010200);
        chk("abort stray", mem[16'h0500], 8'h00);

        @(negedge clk);
        src = 16'h0300; dst = 16'h0600; len = 16'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst pre bus", {dif.cs, dif.rw, dif.addr}, {1'b1, 1'b0, 16'h0601});
        #2 rst = 1'b1;
        #1;
        chk("rst async cs", dif.cs, 0);
        chk("rst async outs", {busy, done, err, count}, 19'h0);
        chk("rst async bus", {dif.rw, dif.addr, dif.wdata}, {1'b1, 16'h0000, 8'h00});
        @(negedge clk);
        rst = 1'b0;
        chk("rst ram kept", mem[16'h0600], 8'h01);
        chk("rst ram no partial", mem[16'h0601], 8'h00);
        chk("no rom write", rom_wr, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
